// File: rtl/rmw_long_latency_pkg.sv
// rmw_long_latency_pkg: shared types and helpers for the RMW long-latency lookup path.
package rmw_long_latency_pkg;

  localparam int unsigned IN_FLIGHT_N_DEF = 16;
  localparam int unsigned PICK_MAX_N      = 64;
  localparam int unsigned PICK_IW         = $clog2(PICK_MAX_N);

  typedef logic [15:0]                        id_t;
  typedef logic [31:0]                        word_t;
  typedef logic [$clog2(IN_FLIGHT_N_DEF)-1:0] sched_tag_t;

  // Index of the lowest clear bit of v; PICK_MAX_N when every bit is set.
  function automatic int unsigned lowest_zero(input logic [PICK_MAX_N-1:0] v);
    int unsigned idx;
    idx = PICK_MAX_N;
    for (int unsigned i = PICK_MAX_N; i > 0; i--) begin
      if (!v[PICK_IW'(i - 1)]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rmw_tbl_sched_pick.sv
// rmw_tbl_sched_pick: lowest-numbered free tag selection from the busy vector.
// N must be a power of two, at most PICK_MAX_N.
module rmw_tbl_sched_pick
  import rmw_long_latency_pkg::*;
#(
  parameter int unsigned N = IN_FLIGHT_N_DEF
) (
  input  logic [N-1:0]         busy,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] tag,
  output logic                 any_free
);

  localparam int unsigned TW = $clog2(N);

  logic [PICK_MAX_N-1:0] padded;
  int unsigned           idx;

  // Pad unused positions as busy so they can never be picked.
  always_comb begin
    padded        = '1;
    padded[N-1:0] = busy;
    idx           = lowest_zero(padded);
    any_free      = (idx < N);
    onehot        = '0;
    tag           = '0;
    if (any_free) begin
      onehot = N'(1) << idx;
      tag    = TW'(idx);
    end
  end

endmodule

// File: rtl/rmw_tbl_sched.sv
// rmw_tbl_sched: tag scheduler for long-latency TBL lookups feeding the RMW pipe.
// Optional response timeout enabled by defining RMW_TBL_SCHED_TIMEOUT_EN.
// IN_FLIGHT_N must be a power of two.
module rmw_tbl_sched
  import rmw_long_latency_pkg::*;
#(
  parameter int unsigned IN_FLIGHT_N    = IN_FLIGHT_N_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           issue_vld,
  input  id_t                            issue_id,
  output logic                           issue_rdy,
  output logic                           tbl_req_vld,
  output logic [$clog2(IN_FLIGHT_N)-1:0] tbl_req_tag,
  output id_t                            tbl_req_id,
  input  logic                           tbl_req_rdy,
  input  logic                           tbl_rsp_vld,
  input  logic [$clog2(IN_FLIGHT_N)-1:0] tbl_rsp_tag,
  input  word_t                          tbl_rsp_word,
  output logic                           cmpl_vld,
  output id_t                            cmpl_id,
  output word_t                          cmpl_word,
  output logic                           err_spurious,
  output logic                           err_timeout,
  output logic [$clog2(IN_FLIGHT_N)-1:0] err_tag,
  output logic [$clog2(IN_FLIGHT_N):0]   busy_cnt
);

  localparam int unsigned TW = $clog2(IN_FLIGHT_N);
  typedef logic [TW-1:0] tag_t;

  if (TIMEOUT_CYCLES == 0) begin : g_cfg_chk
    $fatal(1, "rmw_tbl_sched: TIMEOUT_CYCLES must be nonzero");
  end

  logic [IN_FLIGHT_N-1:0] busy_q, busy_d;
  id_t                    id_q [IN_FLIGHT_N];
  id_t                    id_d [IN_FLIGHT_N];
  logic                   req_vld_q, req_vld_d;
  tag_t                   req_tag_q, req_tag_d;
  id_t                    req_id_q, req_id_d;
  logic                   cmpl_vld_q, cmpl_vld_d;
  id_t                    cmpl_id_q, cmpl_id_d;
  word_t                  cmpl_word_q, cmpl_word_d;
  logic                   err_spurious_q, err_spurious_d;
  logic                   err_timeout_q, err_timeout_d;
  tag_t                   err_tag_q, err_tag_d;
  logic [TW:0]            busy_cnt_q, busy_cnt_d;

  logic [IN_FLIGHT_N-1:0] pick_oh;
  tag_t                   pick_tag;
  logic                   any_free;
  logic                   id_hazard;
  logic                   accept;
  logic                   rsp_hit;
  logic                   tmo_fire;
  tag_t                   tmo_tag;

  rmw_tbl_sched_pick #(
    .N(IN_FLIGHT_N)
  ) u_pick (
    .busy     (busy_q),
    .onehot   (pick_oh),
    .tag      (pick_tag),
    .any_free (any_free)
  );

  // Same-id hazard against registered busy state, so a response never clears it early.
  always_comb begin
    id_hazard = 1'b0;
    for (int unsigned i = 0; i < IN_FLIGHT_N; i++) begin
      if (busy_q[TW'(i)] && (id_q[TW'(i)] == issue_id)) id_hazard = 1'b1;
    end
  end

  assign issue_rdy = rst_n & any_free & (~req_vld_q | tbl_req_rdy) & ~id_hazard;
  assign accept    = issue_vld & issue_rdy;
  assign rsp_hit   = tbl_rsp_vld & busy_q[tbl_rsp_tag];

`ifdef RMW_TBL_SCHED_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  typedef logic [TCW-1:0] tcnt_t;

  tcnt_t tcnt_q [IN_FLIGHT_N];
  tcnt_t tcnt_d [IN_FLIGHT_N];

  // Age busy tags; counters saturate at the limit so a tag deferred behind a
  // lower timed-out tag retires on a later cycle, and a response wins the race.
  always_comb begin
    tmo_fire = 1'b0;
    tmo_tag  = '0;
    for (int unsigned i = 0; i < IN_FLIGHT_N; i++) begin
      tcnt_d[TW'(i)] = tcnt_q[TW'(i)];
      if (busy_q[TW'(i)]) begin
        if (tcnt_q[TW'(i)] != tcnt_t'(TIMEOUT_CYCLES - 1)) begin
          tcnt_d[TW'(i)] = tcnt_q[TW'(i)] + 1'b1;
        end else if (!tmo_fire && !(rsp_hit && (tbl_rsp_tag == TW'(i)))) begin
          tmo_fire = 1'b1;
          tmo_tag  = TW'(i);
        end
      end
      if (accept && (pick_tag == TW'(i))) tcnt_d[TW'(i)] = '0;
    end
  end

  // Per-tag age counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt_q <= '{default: '0};
    else        tcnt_q <= tcnt_d;
  end
`else
  // No timeout logic in this build.
  always_comb begin
    tmo_fire = 1'b0;
    tmo_tag  = '0;
  end
`endif

  // Allocation, request register, completion and error next-state.
  always_comb begin
    busy_d    = busy_q;
    id_d      = id_q;
    req_vld_d = req_vld_q;
    req_tag_d = req_tag_q;
    req_id_d  = req_id_q;
    if (accept) begin
      busy_d         = busy_q | pick_oh;
      id_d[pick_tag] = issue_id;
      req_vld_d      = 1'b1;
      req_tag_d      = pick_tag;
      req_id_d       = issue_id;
    end else if (tbl_req_rdy) begin
      req_vld_d = 1'b0;
    end
    if (rsp_hit)  busy_d[tbl_rsp_tag] = 1'b0;
    if (tmo_fire) busy_d[tmo_tag]     = 1'b0;

    cmpl_vld_d     = rsp_hit;
    cmpl_id_d      = id_q[tbl_rsp_tag];
    cmpl_word_d    = tbl_rsp_word;
    err_spurious_d = tbl_rsp_vld & ~rsp_hit;
    err_timeout_d  = tmo_fire;
    err_tag_d      = '0;
    if (err_spurious_d) err_tag_d = tbl_rsp_tag;
    else if (tmo_fire)  err_tag_d = tmo_tag;

    busy_cnt_d = busy_cnt_q + (TW+1)'(accept) - (TW+1)'(rsp_hit) - (TW+1)'(tmo_fire);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q         <= '0;
      id_q           <= '{default: '0};
      req_vld_q      <= 1'b0;
      req_tag_q      <= '0;
      req_id_q       <= '0;
      cmpl_vld_q     <= 1'b0;
      cmpl_id_q      <= '0;
      cmpl_word_q    <= '0;
      err_spurious_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_tag_q      <= '0;
      busy_cnt_q     <= '0;
    end else begin
      busy_q         <= busy_d;
      id_q           <= id_d;
      req_vld_q      <= req_vld_d;
      req_tag_q      <= req_tag_d;
      req_id_q       <= req_id_d;
      cmpl_vld_q     <= cmpl_vld_d;
      cmpl_id_q      <= cmpl_id_d;
      cmpl_word_q    <= cmpl_word_d;
      err_spurious_q <= err_spurious_d;
      err_timeout_q  <= err_timeout_d;
      err_tag_q      <= err_tag_d;
      busy_cnt_q     <= busy_cnt_d;
    end
  end

  assign tbl_req_vld  = req_vld_q;
  assign tbl_req_tag  = req_tag_q;
  assign tbl_req_id   = req_id_q;
  assign cmpl_vld     = cmpl_vld_q;
  assign cmpl_id      = cmpl_id_q;
  assign cmpl_word    = cmpl_word_q;
  assign err_spurious = err_spurious_q;
  assign err_timeout  = err_timeout_q;
  assign err_tag      = err_tag_q;
  assign busy_cnt     = busy_cnt_q;

endmodule

// File: tb/tb_rmw_tbl_sched.sv
// tb_rmw_tbl_sched: directed scoreboard bench for rmw_tbl_sched.
module tb_rmw_tbl_sched;
  import rmw_long_latency_pkg::*;

`ifdef RMW_TBL_SCHED_TIMEOUT_EN
  localparam int unsigned TB_TMO = 8;
`else
  localparam int unsigned TB_TMO = 255;
`endif
  localparam int unsigned N = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_vld = 1'b0;
  id_t        issue_id = '0;
  logic       issue_rdy;
  logic       tbl_req_vld;
  sched_tag_t tbl_req_tag;
  id_t        tbl_req_id;
  logic       tbl_req_rdy = 1'b0;
  logic       tbl_rsp_vld = 1'b0;
  sched_tag_t tbl_rsp_tag = '0;
  word_t      tbl_rsp_word = '0;
  logic       cmpl_vld;
  id_t        cmpl_id;
  word_t      cmpl_word;
  logic       err_spurious;
  logic       err_timeout;
  sched_tag_t err_tag;
  logic [4:0] busy_cnt;

  logic [19:0] q_req [$];
  logic [47:0] q_cmpl [$];
  sched_tag_t  q_spur [$];
  sched_tag_t  q_tmo [$];
  int n_tests = 0;
  int n_fail  = 0;

  rmw_tbl_sched #(
    .IN_FLIGHT_N    (N),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_vld    (issue_vld),
    .issue_id     (issue_id),
    .issue_rdy    (issue_rdy),
    .tbl_req_vld  (tbl_req_vld),
    .tbl_req_tag  (tbl_req_tag),
    .tbl_req_id   (tbl_req_id),
    .tbl_req_rdy  (tbl_req_rdy),
    .tbl_rsp_vld  (tbl_rsp_vld),
    .tbl_rsp_tag  (tbl_rsp_tag),
    .tbl_rsp_word (tbl_rsp_word),
    .cmpl_vld     (cmpl_vld),
    .cmpl_id      (cmpl_id),
    .cmpl_word    (cmpl_word),
    .err_spurious (err_spurious),
    .err_timeout  (err_timeout),
    .err_tag      (err_tag),
    .busy_cnt     (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_unexp(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got unexpected/missing event, want expected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input id_t id, input sched_tag_t exp_tag);
    bit done;
    done = 1'b0;
    issue_vld = 1'b1;
    issue_id  = id;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (issue_rdy) begin
        q_req.push_back({exp_tag, id});
        done = 1'b1;
      end
      tick();
    end
    issue_vld = 1'b0;
    if (!done) fail_unexp("issue_timeout");
  endtask

  task automatic rsp_drive(input sched_tag_t tag, input word_t w);
    tbl_rsp_vld  = 1'b1;
    tbl_rsp_tag  = tag;
    tbl_rsp_word = w;
    tick();
    tbl_rsp_vld = 1'b0;
  endtask

  task automatic rsp_ok(input sched_tag_t tag, input word_t w, input id_t id);
    q_cmpl.push_back({id, w});
    rsp_drive(tag, w);
  endtask

  task automatic rsp_spur(input sched_tag_t tag);
    q_spur.push_back(tag);
    rsp_drive(tag, 32'hBAD0_0000);
  endtask

  // Monitor: every DUT output event is matched against the scoreboard queues.
  always @(negedge clk) begin
    logic [19:0] er;
    logic [47:0] ec;
    sched_tag_t  et;
    if (rst_n) begin
      if (tbl_req_vld && tbl_req_rdy) begin
        if (q_req.size() == 0) fail_unexp("req_unexpected");
        else begin
          er = q_req.pop_front();
          chk("req_tag", tbl_req_tag, er[19:16]);
          chk("req_id", tbl_req_id, er[15:0]);
        end
      end
      if (cmpl_vld) begin
        if (q_cmpl.size() == 0) fail_unexp("cmpl_unexpected");
        else begin
          ec = q_cmpl.pop_front();
          chk("cmpl_id", cmpl_id, ec[47:32]);
          chk("cmpl_word", cmpl_word, ec[31:0]);
        end
      end
      if (err_spurious) begin
        if (q_spur.size() == 0) fail_unexp("spur_unexpected");
        else begin
          et = q_spur.pop_front();
          chk("spur_tag", err_tag, et);
        end
      end
      if (err_timeout) begin
        if (q_tmo.size() == 0) fail_unexp("tmo_unexpected");
        else begin
          et = q_tmo.pop_front();
          if (!err_spurious) chk("tmo_tag", err_tag, et);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_cnt", busy_cnt, 0);
    chk("rst_issue_rdy", issue_rdy, 0);
    chk("rst_req_vld", tbl_req_vld, 0);
    chk("rst_cmpl_vld", cmpl_vld, 0);
    chk("rst_err_spur", err_spurious, 0);
    chk("rst_err_tag", err_tag, 0);
    rst_n = 1'b1;
    tbl_req_rdy = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", issue_rdy, 1);
    tick();

`ifdef RMW_TBL_SCHED_TIMEOUT_EN
    // Timeout: no response for 8 cycles after allocation.
    issue(16'h0055, 4'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("tmo_wait_busy", busy_cnt, 1);
      tick();
    end
    q_tmo.push_back(4'd0);
    @(negedge clk);
    chk("tmo_freed", busy_cnt, 0);
    tick();
    @(negedge clk);
    chk("tmo_pulse", err_timeout, 0);
    tick();
    rsp_spur(4'd0);
    @(negedge clk);
    chk("tmo_late_no_cmpl", cmpl_vld, 0);
    tick();
`else
    // Single lookup, response 20 cycles later.
    issue(16'h0012, 4'd0);
    @(negedge clk);
    chk("t1_req_lat", tbl_req_vld, 1);
    chk("t1_busy_cnt", busy_cnt, 1);
    repeat (19) tick();
    rsp_ok(4'd0, 32'hDEAD_BEEF, 16'h0012);
    @(negedge clk);
    chk("t1_cmpl_lat", cmpl_vld, 1);
    chk("t1_busy_zero", busy_cnt, 0);
    tick();

    // Fill all tags, then free tag 5 and watch it get reused.
    for (int i = 0; i < 16; i++) issue(id_t'(16'h0100 + i), sched_tag_t'(i));
    issue_vld = 1'b1;
    issue_id  = 16'h0110;
    @(negedge clk);
    chk("full_rdy", issue_rdy, 0);
    chk("full_cnt", busy_cnt, 16);
    tick();
    q_cmpl.push_back({16'h0105, 32'h5555_0005});
    tbl_rsp_vld = 1'b1; tbl_rsp_tag = 4'd5; tbl_rsp_word = 32'h5555_0005;
    @(negedge clk);
    chk("free_same_cycle", issue_rdy, 0);
    tick();
    tbl_rsp_vld = 1'b0;
    @(negedge clk);
    chk("realloc_rdy", issue_rdy, 1);
    chk("realloc_cnt", busy_cnt, 15);
    q_req.push_back({4'd5, 16'h0110});
    tick();
    issue_vld = 1'b0;
    @(negedge clk);
    chk("refull_cnt", busy_cnt, 16);
    tick();
    for (int i = 0; i < 16; i++)
      rsp_ok(sched_tag_t'(i), word_t'(32'hA000_0000 + i), (i == 5) ? 16'h0110 : id_t'(16'h0100 + i));
    @(negedge clk);
    chk("drain_cnt", busy_cnt, 0);
    tick();

    // Same id issued twice: second waits for the first response.
    issue(16'h0007, 4'd0);
    issue_vld = 1'b1;
    issue_id  = 16'h0007;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hazard_hold", issue_rdy, 0);
      tick();
    end
    q_cmpl.push_back({16'h0007, 32'h0000_7777});
    tbl_rsp_vld = 1'b1; tbl_rsp_tag = 4'd0; tbl_rsp_word = 32'h0000_7777;
    @(negedge clk);
    chk("hazard_rsp_cycle", issue_rdy, 0);
    tick();
    tbl_rsp_vld = 1'b0;
    @(negedge clk);
    chk("hazard_release", issue_rdy, 1);
    q_req.push_back({4'd0, 16'h0007});
    tick();
    issue_vld = 1'b0;
    rsp_ok(4'd0, 32'h0000_0001, 16'h0007);

    // Request channel stalled for 10 cycles.
    tbl_req_rdy = 1'b0;
    issue(16'h0300, 4'd0);
    issue_vld = 1'b1;
    issue_id  = 16'h0301;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_rdy", issue_rdy, 0);
      chk("stall_vld", tbl_req_vld, 1);
      chk("stall_tag", tbl_req_tag, 0);
      chk("stall_id", tbl_req_id, 16'h0300);
      chk("stall_cnt", busy_cnt, 1);
      tick();
    end
    tbl_req_rdy = 1'b1;
    @(negedge clk);
    chk("unstall_rdy", issue_rdy, 1);
    q_req.push_back({4'd1, 16'h0301});
    tick();
    issue_vld = 1'b0;
    rsp_ok(4'd0, 32'h3000_0000, 16'h0300);
    rsp_ok(4'd1, 32'h3000_0001, 16'h0301);

    // Spurious response on an idle tag.
    rsp_spur(4'd3);
    @(negedge clk);
    chk("spur_no_cmpl", cmpl_vld, 0);
    chk("spur_cnt", busy_cnt, 0);
    tick();
    @(negedge clk);
    chk("spur_pulse", err_spurious, 0);
    tick();

    // Mid-operation reset with 4 tags busy.
    for (int i = 0; i < 4; i++) issue(id_t'(16'h0400 + i), sched_tag_t'(i));
    tick();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_cnt", busy_cnt, 0);
    chk("mid_rst_rdy", issue_rdy, 0);
    chk("mid_rst_req", tbl_req_vld, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_mid_rst_rdy", issue_rdy, 1);
    tick();
    rsp_spur(4'd1);
    @(negedge clk);
    chk("post_rst_no_cmpl", cmpl_vld, 0);
    tick();
`endif

    repeat (3) tick();
    chk("q_req_left", q_req.size(), 0);
    chk("q_cmpl_left", q_cmpl.size(), 0);
    chk("q_spur_left", q_spur.size(), 0);
    chk("q_tmo_left", q_tmo.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
